// File: rtl/or_chk_pkg.sv
// ==== or_chk_pkg : shared types, constants and expected-value helper for the OR-gate checker ====
// ==== Rev 1.0 ====
`default_nettype none

package or_chk_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    CHECK    = 3'd2,
    WAIT_CHG = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [15:0] FULL_COVERAGE = 16'hFFFF;

  // All three gate outputs mirror the OR of the four inputs.
  function automatic logic [2:0] exp_out(input logic [3:0] in);
    return {3{|in}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/or_gate_response_checker_stable_detector.sv
// ==== stable_detector : registers the gate inputs and counts consecutive stable cycles ====
// ==== Rev 1.0 ====
`default_nettype none

module stable_detector #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_vec,
  output logic [3:0] in_q,
  output logic       changed,
  output logic       stable
);

  logic [3:0] in_prev;
  logic [3:0] stable_cnt;

  // The counter is evaluated against the values in_q/in_prev take at this edge,
  // so stable_cnt always describes the registered pair it sits beside.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q       <= '0;
      in_prev    <= '0;
      stable_cnt <= '0;
    end else begin
      in_q    <= in_vec;
      in_prev <= in_q;
      if (in_vec != in_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt != 4'hF) begin
        stable_cnt <= stable_cnt + 4'd1;
      end
    end
  end

  assign changed = (in_q != in_prev);
  assign stable  = (stable_cnt >= 4'(SETTLE_CYCLES));

endmodule

`default_nettype wire

// File: rtl/or_gate_response_checker.sv
// ==== or_gate_response_checker : self-check of a 4-input OR gate with coverage and mismatch count ====
// ==== Rev 1.0 : FIRST_FAIL_CAPTURE_EN builds the fail_vec/fail_out first-failure capture ====
`default_nettype none

module or_gate_response_checker
  import or_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [3:0]       in_vec,
  input  logic [2:0]       dut_out,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             error,
  output logic [15:0]      coverage,
  output logic             done,
  output logic [3:0]       fail_vec,
  output logic [2:0]       fail_out
);

  state_t      state, state_nx;
  logic [3:0]  in_q;
  logic [2:0]  out_q;
  logic        changed;
  logic        stable;
  logic        is_check;
  logic        pass;
  logic [15:0] cov_set;

  stable_detector #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_stable (
    .clk     (clk),
    .rst     (rst),
    .in_vec  (in_vec),
    .in_q    (in_q),
    .changed (changed),
    .stable  (stable)
  );

  assign is_check = (state == CHECK);
  assign pass     = (out_q == exp_out(in_q));
  assign cov_set  = coverage | (16'(pass) << in_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_q <= '0;
    end else begin
      state <= state_nx;
      out_q <= dut_out;
    end
  end

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:     state_nx = SETTLE;
        SETTLE:   if (stable) state_nx = CHECK;
        CHECK:    state_nx = (cov_set == FULL_COVERAGE) ? DONE : WAIT_CHG;
        WAIT_CHG: if (changed) state_nx = SETTLE;
        DONE:     state_nx = DONE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  // clear outranks a same-cycle compare, so a failing CHECK under clear is dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mismatch_cnt <= '0;
      error        <= 1'b0;
      coverage     <= '0;
    end else if (is_check) begin
      coverage <= cov_set;
      if (!pass) begin
        error <= 1'b1;
        if (mismatch_cnt != {CNT_W{1'b1}}) begin
          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign done = (state == DONE);

`ifdef FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fail_vec <= '0;
      fail_out <= '0;
    end else if (is_check && !pass && !error) begin
      fail_vec <= in_q;
      fail_out <= out_q;
    end
  end
`else
  assign fail_vec = '0;
  assign fail_out = '0;
`endif

endmodule

`default_nettype wire

// File: doc/or_gate_response_checker.md
# or_gate_response_checker

Synthesizable response checker that sits at the observing end of the 4-input OR gate stimulus path. It samples the four gate inputs and the three gate outputs on every clock. Once the inputs have been stable long enough, it compares the outputs against the expected OR value. It tracks coverage of all 16 input combinations and reports mismatches, so that gate variants can be self-checked on the board or in simulation without a waveform review.

## Interface
- SETTLE_CYCLES, 2: consecutive stable cycles required before a compare; legal range 1–15.
- CNT_W, 8: width of the mismatch counter.

- clk   input   1       system clock; all state updates on the rising edge.
- rst   input   1       synchronous, active-high reset.
- en   input   1       check enable; while low, the FSM holds in IDLE.
- clear   input   1       synchronous clear of the counter, coverage, error and capture registers; FSM state is not affected.
- in_vec   input   4       gate inputs {a,b,c,d}, with a as the MSB.
- dut_out   input   3       gate outputs {e,f,g}.
- mismatch_cnt   output   CNT_W   number of failing compares; saturates at its maximum value.
- error   output   1       sticky; high after the first mismatch.
- coverage   output   16      bit i is set once input combination i has passed through a compare.
- done   output   1       high while the FSM is in DONE.
- fail_vec   output   4       in_vec of the first failing compare.
- fail_out   output   3       dut_out of the first failing compare.

## Operation
- Expected value: every bit of dut_out must equal |in_vec, i.e. 3'b111 when any input is 1, otherwise 3'b000. Any differing bit makes the compare a mismatch.
- Input registers:
  - in_q and out_q register in_vec and dut_out every cycle.
  - in_prev registers in_q.
  - stable_cnt (4 bits) resets to 0 whenever in_q != in_prev.
  - Otherwise stable_cnt increments, saturating at 15.
- FSM states are IDLE, SETTLE, CHECK, WAIT_CHG and DONE:
  - IDLE → SETTLE when en=1.
  - SETTLE → CHECK when stable_cnt >= SETTLE_CYCLES.
  - CHECK (one cycle) compares out_q against in_q:
    - If the compare passes, set coverage[in_q].
    - If it fails, do the following:
      - increment mismatch_cnt, saturating;
      - set error;
      - capture fail_vec/fail_out, but only when error was previously 0.
    - CHECK → DONE if the updated coverage == 16'hFFFF; otherwise CHECK → WAIT_CHG.
  - WAIT_CHG → SETTLE when in_q != in_prev.
  - DONE holds until rst, or until en=0, which returns the FSM to IDLE.
- Any state other than DONE returns to IDLE when en=0. Counters, coverage and captures are kept.
- A coverage bit is set only by a passing compare. A combination that has only ever failed stays uncovered, so done cannot assert in that case.
- Input change during SETTLE: stable_cnt resets and the FSM stays in SETTLE. No compare is made for the abandoned value.
- Simultaneous clear and a CHECK mismatch: clear wins. Counter, error and coverage end at 0; the compare result is dropped.
- Repeated combination: it is compared again on every visit; its coverage bit is already set, and mismatches still count.

## Timing
- Reset values:
  - every output is 0;
  - the FSM is in IDLE;
  - in_q, in_prev and out_q are 0;
  - stable_cnt is 0.
- Compare latency: an in_vec change sampled at edge n reaches in_q at edge n. The CHECK cycle occurs at edge n+SETTLE_CYCLES+1, and its results are visible at edge n+SETTLE_CYCLES+2.
- dut_out must be valid by the CHECK edge. The gate's combinational delay is absorbed by the settle window.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-check: rst takes effect at the next edge, and all state returns to its reset values.

## Configuration
- FIRST_FAIL_CAPTURE_EN defined: the fail_vec/fail_out capture registers are built as described in Operation.
- FIRST_FAIL_CAPTURE_EN undefined:
  - fail_vec and fail_out are tied to 0 and no capture flops exist;
  - mismatch_cnt, error, coverage and done are unchanged.

## Structure
- Shared package or_chk_pkg contains:
  - the state enum (IDLE, SETTLE, CHECK, WAIT_CHG, DONE);
  - the constant FULL_COVERAGE = 16'hFFFF;
  - the function exp_out(in) that returns the 3-bit expected vector.
- Sub-module stable_detector:
  - contains in_q, in_prev and stable_cnt;
  - outputs in_q, changed, and stable (stable_cnt >= SETTLE_CYCLES).
- The top level holds the FSM, counter, coverage and capture logic.

## Test plan
- Exhaustive walk: SETTLE_CYCLES=2, a correct OR model, and in_vec stepped 0→15, each value held 5 cycles. Required: done=1 after the compare of value 15, coverage=16'hFFFF, mismatch_cnt=0, error=0.
- Fault injection: dut_out forced to 3'b110 for in_vec=4'b0101, with the full walk applied. Required:
  - mismatch_cnt=1 and error=1;
  - fail_vec=4'b0101, fail_out=3'b110;
  - coverage[5]=0, done=0.
- Glitch rejection: in_vec toggled every cycle for 10 cycles, then held at 4'b1000. Required: exactly one compare occurs, coverage=16'h0100, stable_cnt restarts on every toggle.
- Clear vs. mismatch: clear asserted in the same cycle as a failing CHECK. Required: mismatch_cnt=0, error=0, coverage=0 on the next cycle.
- Saturation: CNT_W=2 and 5 failing compares. Required: mismatch_cnt=3.
- Enable and reset: en dropped during SETTLE, and rst pulsed during WAIT_CHG. Required:
  - dropping en returns the FSM to IDLE with coverage held;
  - the rst pulse zeroes all outputs on the next edge.
